control_unit: RTL
=================

# control_unit

Hardwired Mini SRC control sequencer sitting directly upstream of the datapath. It steps a fetch/decode/execute state machine, decodes the instruction register's opcode and field usage, and drives every datapath control strobe: register select, bus-source enables, register load enables, ALU opcode, and memory read/write. It stops on `halt`. Outputs are decoded from the current state and `ir`; the datapath samples them on the next rising `clk`.

## Interface
Parameters:
- `ADD_OP`, 5'b00011: ALU opcode driven for address and branch-target computation.

Ports:
- `clk` input 1: single system clock; all state changes on rising edge.
- `clr` input 1: asynchronous, active-low reset.
- `ir` input 32: instruction register contents; opcode is `ir[31:27]`.
- `con_ff` input 1: branch condition flip-flop output.
- `step` input 1: single-step advance pulse; only present when `CU_SINGLE_STEP_EN` is defined.
- `run` output 1: 1 while executing; 0 in reset or after `halt`.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAOut` output 1 each: register select/encode controls.
- `PCout`, `MDRout`, `ZHIout`, `ZLOout`, `HIout`, `Loout`, `InPortout`, `Cout` output 1 each: bus-source enables.
- `PCin`, `IncPC`, `IRin`, `MARin`, `MDRin`, `MDRread`, `Yin`, `Zin`, `HIin`, `Loin`, `OutPortin`, `CON_ff_in`, `RAM_write` output 1 each: load and memory strobes.
- `ALU_opcode` output 5: ALU operation select.

## Operation
- **States:** RESET, T0–T7, HALTED, plus WAIT when single-step is compiled in. Any strobe not listed for a state is 0.
- **Fetch:**
  - T0: `PCout`, `MARin`, `IncPC`.
  - T1: `MDRread`, `MDRin`.
  - T2: `MDRout`, `IRin`.
- **Execute, by opcode** (class listed, then steps from T3):
  - R-type ALU (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011): T3 `Grb`,`Rout`,`Yin`; T4 `Grc`,`Rout`,`Zin`, `ALU_opcode`=op; T5 `ZLOout`,`Gra`,`Rin`.
  - Immediate (addi 01100, andi 01101, ori 01110): same as R-type, but T4 uses `Cout` in place of `Grc`,`Rout`.
  - div 01111 / mul 10000: T3 `Gra`,`Rout`,`Yin`; T4 `Grb`,`Rout`,`Zin`,op; T5 `ZLOout`,`Loin`; T6 `ZHIout`,`HIin`.
  - neg 10001 / not 10010: T3 `Grb`,`Rout`,`Zin`,op; T4 `ZLOout`,`Gra`,`Rin`.
  - ld 00000 / st 00010: T3 `Grb`,`BAOut`,`Yin`; T4 `Cout`,`Zin`,`ADD_OP`; T5 `ZLOout`,`MARin`.
    - ld continues: T6 `MDRread`,`MDRin`; T7 `MDRout`,`Gra`,`Rin`.
    - st continues: T6 `Gra`,`Rout`,`MDRin` with `MDRread`=0; T7 `RAM_write`.
  - ldi 00001: T3–T4 as ld; T5 `ZLOout`,`Gra`,`Rin`.
  - br 10011: T3 `Gra`,`Rout`,`CON_ff_in`; T4 `PCout`,`Yin`; T5 `Cout`,`Zin`,`ADD_OP`; T6 `ZLOout`, with `PCin`=`con_ff`.
  - jal 10100: T3 `PCout`,`Grb`,`Rin` (rb field = 1111 by ISA); T4 `Gra`,`Rout`,`PCin`.
  - jr 10101: T3 `Gra`,`Rout`,`PCin`.
  - in 10110: T3 `InPortout`,`Gra`,`Rin`.
  - out 10111: T3 `Gra`,`Rout`,`OutPortin`.
  - mflo 11000: T3 `Loout`,`Gra`,`Rin`.
  - mfhi 11001: T3 `HIout`,`Gra`,`Rin`.
  - nop 11010, and all undefined opcodes: T3 with no strobes.
  - halt 11011: T3 leads to HALTED.
- **After the final step:** the next state is T0.
- **`ALU_opcode`:** 0 in every state where `Zin`=0.

## Timing
- **Reset:**
  - `clr` low: state forced to RESET at once, regardless of the current step. All outputs read 0, including `run`.
  - First rising edge after `clr` goes high: RESET moves to T0.
- **Cycles per instruction, fetch included:**
  - 4: jr, in, out, mfhi, mflo, nop.
  - 5: jal, neg, not.
  - 6: R-type, immediate, ldi.
  - 7: mul, div, br.
  - 8: ld, st.
- **Sampling rules:**
  - `con_ff` is sampled only in br T6.
  - `ir` is decoded from T3 onward and must be stable from the T2 edge until the instruction ends.
- **HALTED:** all strobes 0 and `run`=0. The block leaves HALTED only through `clr`.
- **Control-strobe exclusivity:** no state asserts two bus-source enables at once; the bench checks this every cycle.

## Configuration
- `CU_SINGLE_STEP_EN` defined:
  - The `step` input exists.
  - After each instruction's final step the FSM enters WAIT, with strobes 0 and `run`=1.
  - WAIT goes to T0 on the first cycle `step`=1.
  - If `step` is held high, the block advances one instruction per WAIT visit.
- Not defined: no `step` port and no WAIT state; the final step goes directly to T0.

## Test plan
- **Reset:** hold `clr`=0 for 3 cycles, then release. Expect all outputs 0 during reset, then T0 on the first edge with `PCout`=`MARin`=`IncPC`=1.
- **add:** `ir`=0x18B98000 (add r1,r7,r3). Expect T3 `Grb`/`Rout`/`Yin`, T4 `Grc`/`Rout`/`Zin` with `ALU_opcode`=00011, T5 `ZLOout`/`Gra`/`Rin`; the next T0 falls on cycle 7.
- **st:** `ir`=0x10800090. Expect T4 `ALU_opcode`=00011, T6 `MDRin`=1 with `MDRread`=0, T7 `RAM_write`=1. Total 8 cycles.
- **br:** run with `con_ff`=0, then with `con_ff`=1. Expect `PCin` in T6 to be 0 and 1 respectively, with `ZLOout`=1 in both.
- **Halt:** `ir`=0xD8000000. Expect `run` to drop after T3 and stay 0 for 20 cycles. Then pulse `clr` low mid-cycle and expect outputs to go to 0 immediately.
- **Single-step** (macro defined): after a nop, expect the FSM to stay in WAIT with `step`=0 for 10 cycles; a one-cycle `step` pulse gives T0 on the next edge.

Source files
------------

// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer: fetch/decode/execute FSM driving every datapath strobe.
// Optional single-step WAIT state is compiled in with `define CU_SINGLE_STEP_EN.
module control_unit #(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
`ifdef CU_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        run,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAOut,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZHIout,
    output logic        ZLOout,
    output logic        HIout,
    output logic        Loout,
    output logic        InPortout,
    output logic        Cout,
    output logic        PCin,
    output logic        IncPC,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRread,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        Loin,
    output logic        OutPortin,
    output logic        CON_ff_in,
    output logic        RAM_write,
    output logic [4:0]  ALU_opcode
);
    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SHL  = 5'd11, OP_ADDI = 5'd12, OP_ORI  = 5'd14, OP_DIV  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18, OP_BR   = 5'd19;
    localparam logic [4:0] OP_JAL  = 5'd20, OP_JR   = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24, OP_MFHI = 5'd25, OP_HALT = 5'd27;

    // T-states share their step number with the low three bits of the encoding.
    typedef enum logic [3:0] {
        S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
        S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
        S_RESET = 4'd8,
`ifdef CU_SINGLE_STEP_EN
        S_WAIT = 4'd10,
`endif
        S_HALTED = 4'd9
    } state_t;

`ifdef CU_SINGLE_STEP_EN
    localparam state_t S_AFTER = S_WAIT;
`else
    localparam state_t S_AFTER = S_T0;
`endif

    state_t     state_q, state_d;
    logic [4:0] op;
    logic [2:0] t;
    logic [2:0] last_step;
    logic       unused_ir_bits;

    assign op             = ir[31:27];
    assign t              = state_q[2:0];
    assign unused_ir_bits = ^ir[26:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= S_RESET;
        else      state_q <= state_d;
    end

    always_comb begin
        last_step = 3'd3;
        case (op) inside
            [OP_ADD:OP_ORI], OP_LDI:  last_step = 3'd5;
            OP_DIV, OP_MUL, OP_BR:    last_step = 3'd6;
            OP_LD, OP_ST:             last_step = 3'd7;
            OP_NEG, OP_NOT, OP_JAL:   last_step = 3'd4;
            default:                  last_step = 3'd3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_T0;
            S_T0:     state_d = S_T1;
            S_T1:     state_d = S_T2;
            S_T2:     state_d = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (state_q == S_T3 && op == OP_HALT) state_d = S_HALTED;
                else if (t == last_step)              state_d = S_AFTER;
                else                                  state_d = state_t'(state_q + 4'd1);
            end
`ifdef CU_SINGLE_STEP_EN
            S_WAIT:   if (step) state_d = S_T0;
`endif
            default:  state_d = state_q;
        endcase
    end

    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAOut} = '0;
        {PCout, MDRout, ZHIout, ZLOout, HIout, Loout, InPortout, Cout} = '0;
        {PCin, IncPC, IRin, MARin, MDRin, MDRread, Yin, Zin, HIin, Loin} = '0;
        {OutPortin, CON_ff_in, RAM_write} = '0;
        ALU_opcode = 5'd0;
        run = (state_q != S_RESET) && (state_q != S_HALTED);
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            S_T1: begin MDRread = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                case (op) inside
                    [OP_ADD:OP_ORI]: begin
                        if (t == 3'd3) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        if (t == 3'd4) begin
                            if (op >= OP_ADDI) Cout = 1'b1;
                            else begin Grc = 1'b1; Rout = 1'b1; end
                            Zin = 1'b1; ALU_opcode = op;
                        end
                        if (t == 3'd5) begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    end
                    OP_DIV, OP_MUL: begin
                        if (t == 3'd3) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        if (t == 3'd4) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_opcode = op; end
                        if (t == 3'd5) begin ZLOout = 1'b1; Loin = 1'b1; end
                        if (t == 3'd6) begin ZHIout = 1'b1; HIin = 1'b1; end
                    end
                    OP_NEG, OP_NOT: begin
                        if (t == 3'd3) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_opcode = op; end
                        if (t == 3'd4) begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    end
                    OP_LD, OP_ST, OP_LDI: begin
                        if (t == 3'd3) begin Grb = 1'b1; BAOut = 1'b1; Yin = 1'b1; end
                        if (t == 3'd4) begin Cout = 1'b1; Zin = 1'b1; ALU_opcode = ADD_OP; end
                        if (t == 3'd5) begin
                            ZLOout = 1'b1;
                            if (op == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                            else MARin = 1'b1;
                        end
                        if (t == 3'd6) begin
                            MDRin = 1'b1;
                            if (op == OP_LD) MDRread = 1'b1;
                            else begin Gra = 1'b1; Rout = 1'b1; end
                        end
                        if (t == 3'd7) begin
                            if (op == OP_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                            else RAM_write = 1'b1;
                        end
                    end
                    OP_BR: begin
                        if (t == 3'd3) begin Gra = 1'b1; Rout = 1'b1; CON_ff_in = 1'b1; end
                        if (t == 3'd4) begin PCout = 1'b1; Yin = 1'b1; end
                        if (t == 3'd5) begin Cout = 1'b1; Zin = 1'b1; ALU_opcode = ADD_OP; end
                        if (t == 3'd6) begin ZLOout = 1'b1; PCin = con_ff; end
                    end
                    OP_JAL: begin
                        if (t == 3'd3) begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                        if (t == 3'd4) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    end
                    OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                    OP_MFLO: begin Loout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule
